data_mem_ctrl: RTL and testbench

- Parametrised successor to the combinational byte-addressed data memory.
- Adds valid/ready request and response channels, a registered read path and range checking.
- Crossing-word (misaligned) accesses are either split into two beats or rejected.
- Sits between the core's load/store unit and on-chip data storage; one outstanding transaction; big-endian byte order (lowest address = MSB).

---
 rtl/data_mem_pkg.sv | 71 +++++++
 rtl/data_mem_if.sv | 28 ++
 rtl/data_mem_bank.sv | 33 +++
 rtl/data_mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the data memory controller.
// Byte offset 0 within a word is the most significant byte (big-endian).
package data_mem_pkg;

   localparam logic [2:0] MASK_LHU = 3'b001;
   localparam logic [2:0] MASK_LH  = 3'b101;
   localparam logic [2:0] MASK_LBU = 3'b010;
   localparam logic [2:0] MASK_LB  = 3'b110;
   localparam logic [2:0] MASK_W   = 3'b000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BEAT0 = 2'd1;
   localparam logic [1:0] ST_BEAT1 = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Access size in bytes; only the low mask bits select the width.
   function automatic logic [2:0] size_from_mask(input logic [1:0] mask_lo);
      logic [2:0] size;
      case (mask_lo)
         2'b01:   size = 3'd2;
         2'b10:   size = 3'd1;
         default: size = 3'd4;
      endcase
      return size;
   endfunction

   // be[i] enables byte offset i of the word touched by the given beat.
   function automatic logic [3:0] byte_en(input logic [1:0] offset,
                                          input logic [2:0] size,
                                          input logic       beat);
      logic [3:0] be;
      logic [3:0] pos;
      logic [3:0] lo;
      logic [3:0] hi;
      lo = 4'(offset);
      hi = lo + 4'(size);
      for (int i = 0; i < 4; i++) begin
         pos   = 4'(i) + (beat ? 4'd4 : 4'd0);
         be[i] = (pos >= lo) && (pos < hi);
      end
      return be;
   endfunction

   // Right-aligned store data placed into a two-word window: [63:32] beat 0, [31:0] beat 1.
   function automatic logic [63:0] store_lanes(input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  size);
      logic [31:0] left;
      left = wdata << (6'd32 - {size, 3'b000});
      return {left, 32'h0} >> {offset, 3'b000};
   endfunction

   // Extracts the addressed bytes from a two-word window and extends them.
   function automatic logic [31:0] load_align(input logic [63:0] pair,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  mask);
      logic [2:0]  size;
      logic [31:0] top;
      logic [31:0] val;
      size = size_from_mask(mask[1:0]);
      top  = 32'(pair >> (6'd32 - {1'b0, offset, 3'b000}));
      val  = top >> (6'd32 - {size, 3'b000});
      case (mask)
         MASK_LH: val = {{16{val[15]}}, val[15:0]};
         MASK_LB: val = {{24{val[7]}}, val[7:0]};
         default: ;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response channel between the load/store unit and data_mem_ctrl.
interface data_mem_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [2:0]        req_mask_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       rsp_rdata_o;
   logic              rsp_err_o;
   logic              busy_o;

   modport slave (
      input  req_valid_i, req_we_i, req_mask_i, req_addr_i, req_wdata_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
   );

   modport master (
      output req_valid_i, req_we_i, req_mask_i, req_addr_i, req_wdata_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
   );

endinterface

// File: rtl/data_mem_bank.sv
// Single-port word-wide RAM with byte enables and a registered read (1-cycle latency).
// be_i[i] writes byte offset i, i.e. bits [31-8i -: 8]. Contents are never cleared here.
module data_mem_bank #(
   parameter int unsigned WORDS = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < 4; i++) begin
               if (be_i[i]) mem_q[addr_i][8*(3-i) +: 8] <= wdata_i[8*(3-i) +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory controller: valid/ready channels, range check, big-endian lanes.
// Define DATA_MEM_MISALIGN_EN to split word-crossing accesses into two beats; otherwise they fault.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int unsigned MEM_SIZE   = 1024,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned RESET_ZERO = 0
) (
   input logic       clk_i,
   input logic       rst_ni,
   data_mem_if.slave bus
);

   localparam int unsigned WORDS   = MEM_SIZE / 4;
   localparam int unsigned WORD_AW = $clog2(WORDS);
   localparam int unsigned AW1     = ADDR_W + 1;

   // Parameter legality check.
   if (MEM_SIZE < 8 || (MEM_SIZE & (MEM_SIZE - 1)) != 0 || RESET_ZERO > 1) begin : g_param_check
      $error("data_mem_ctrl: illegal parameter set");
   end

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        mask_q, mask_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata0_q, rdata0_d;
   logic              req_ready_q, req_ready_d;
   logic              busy_q, busy_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;

   logic               bank_en;
   logic               bank_we;
   logic [3:0]         bank_be;
   logic [WORD_AW-1:0] bank_addr;
   logic [31:0]        bank_wdata;
   logic [31:0]        bank_rdata;

   logic [2:0]         size;
   logic [1:0]         off;
   logic               crosses;
   logic               range_err;
   logic               acc_err;
   logic [WORD_AW-1:0] word0;
   logic [WORD_AW-1:0] word1;
   logic [63:0]        lanes;
   logic [3:0]         be0;
   logic [3:0]         be1;

   data_mem_bank #(
      .WORDS (WORDS),
      .AW    (WORD_AW)
   ) u_bank (
      .clk_i   (clk_i),
      .en_i    (bank_en),
      .we_i    (bank_we),
      .be_i    (bank_be),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata)
   );

   // Decode of the latched request; range check is done one bit wider so it cannot wrap.
   always_comb begin
      size      = size_from_mask(mask_q[1:0]);
      off       = addr_q[1:0];
      crosses   = (3'(off) + size) > 3'd4;
      range_err = ({1'b0, addr_q} + AW1'(size)) > AW1'(MEM_SIZE);
`ifdef DATA_MEM_MISALIGN_EN
      acc_err   = range_err;
`else
      acc_err   = range_err | crosses;
`endif
      word0     = addr_q[WORD_AW+1:2];
      word1     = word0 + WORD_AW'(1);
      lanes     = store_lanes(wdata_q, off, size);
      be0       = byte_en(off, size, 1'b0);
      be1       = byte_en(off, size, 1'b1);
   end

   // Next-state and output logic. Loads read one cycle ahead so data lands on the beat.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      mask_d      = mask_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata0_d    = rdata0_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      bank_en     = 1'b0;
      bank_we     = 1'b0;
      bank_be     = 4'h0;
      bank_addr   = word0;
      bank_wdata  = lanes[63:32];

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid_i) begin
               we_d      = bus.req_we_i;
               mask_d    = bus.req_mask_i;
               addr_d    = bus.req_addr_i;
               wdata_d   = bus.req_wdata_i;
               bank_en   = 1'b1;
               bank_addr = bus.req_addr_i[WORD_AW+1:2];
               state_d   = ST_BEAT0;
            end
         end

         ST_BEAT0: begin
            if (acc_err) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'h0;
               state_d     = ST_RESP;
            end else begin
               bank_en = we_q;
               bank_we = we_q;
               bank_be = be0;
               if (!crosses) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = we_q ? 32'h0 : load_align({bank_rdata, 32'h0}, off, mask_q);
                  state_d     = ST_RESP;
               end else begin
                  // Split load: fetch the next word while holding the first.
                  if (!we_q) begin
                     bank_en   = 1'b1;
                     bank_addr = word1;
                  end
                  rdata0_d = bank_rdata;
                  state_d  = ST_BEAT1;
               end
            end
         end

         ST_BEAT1: begin
            bank_en     = we_q;
            bank_we     = we_q;
            bank_be     = be1;
            bank_addr   = word1;
            bank_wdata  = lanes[31:0];
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? 32'h0 : load_align({rdata0_q, bank_rdata}, off, mask_q);
            state_d     = ST_RESP;
         end

         ST_RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = 32'h0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         mask_q      <= 3'h0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         rdata0_q    <= 32'h0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         mask_q      <= mask_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata0_q    <= rdata0_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.req_ready_o = req_ready_q;
   assign bus.busy_o      = busy_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (MEM_SIZE 1024); expectations follow DATA_MEM_MISALIGN_EN.
module tb_data_mem_ctrl;
   import data_mem_pkg::*;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   data_mem_if #(.ADDR_W(32)) bus ();

   data_mem_ctrl #(
      .MEM_SIZE   (1024),
      .ADDR_W     (32),
      .RESET_ZERO (0)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Issues one request and returns once rsp_valid_o is seen; lat counts cycles from handshake.
   task automatic start_req(input logic we, input logic [2:0] mask, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat);
      int w;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_mask_i  = mask;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
      w = 0;
      while (!bus.req_ready_o && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      lat = 1;
      while (!bus.rsp_valid_o && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic end_rsp();
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic txn(input string tag, input logic we, input logic [2:0] mask,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int lat;
      start_req(we, mask, addr, wdata, lat);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".rdata"}, bus.rsp_rdata_o, exp_rdata);
      check({tag, ".err"}, 32'(bus.rsp_err_o), 32'(exp_err));
      end_rsp();
   endtask

   initial begin
      int lat;
      clk             = 1'b0;
      rst_n           = 1'b0;
      n_total         = 0;
      n_pass          = 0;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_mask_i  = MASK_W;
      bus.req_addr_i  = 32'h0;
      bus.req_wdata_i = 32'h0;
      bus.rsp_ready_i = 1'b0;

      #12;
      check("rst.req_ready", 32'(bus.req_ready_o), 32'd1);
      check("rst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("rst.rdata", bus.rsp_rdata_o, 32'h0);
      check("rst.err", 32'(bus.rsp_err_o), 32'd0);
      check("rst.busy", 32'(bus.busy_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Aligned word round trip, then byte/half loads with extension.
      txn("sw10", 1'b1, MASK_W, 32'h10, 32'h12345678, 32'h0, 1'b0, 2);
      txn("lw10", 1'b0, MASK_W, 32'h10, 32'h0, 32'h12345678, 1'b0, 2);
      txn("lbu11", 1'b0, MASK_LBU, 32'h11, 32'h0, 32'h00000034, 1'b0, 2);
      txn("sb12", 1'b1, MASK_LBU, 32'h12, 32'h00000080, 32'h0, 1'b0, 2);
      txn("lh12", 1'b0, MASK_LH, 32'h12, 32'h0, 32'hFFFF8078, 1'b0, 2);
      txn("lhu12", 1'b0, MASK_LHU, 32'h12, 32'h0, 32'h00008078, 1'b0, 2);
      txn("lb12", 1'b0, MASK_LB, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      txn("lh11", 1'b0, MASK_LH, 32'h11, 32'h0, 32'h00003480, 1'b0, 2);

      // Word-crossing accesses.
      txn("sw0c", 1'b1, MASK_W, 32'h0C, 32'hAABBCCDD, 32'h0, 1'b0, 2);
      txn("sw10b", 1'b1, MASK_W, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
`ifdef DATA_MEM_MISALIGN_EN
      txn("lw0e", 1'b0, MASK_W, 32'h0E, 32'h0, 32'hCCDD1122, 1'b0, 3);
      txn("lh0f", 1'b0, MASK_LH, 32'h0F, 32'h0, 32'hFFFFDD11, 1'b0, 3);
`else
      txn("lw0e", 1'b0, MASK_W, 32'h0E, 32'h0, 32'h0, 1'b1, 2);
      txn("lh0f", 1'b0, MASK_LH, 32'h0F, 32'h0, 32'h0, 1'b1, 2);
`endif

      // Response back-pressure: outputs hold while rsp_ready_i is low.
      start_req(1'b0, MASK_W, 32'h10, 32'h0, lat);
      check("stall.lat", 32'(lat), 32'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall.valid", 32'(bus.rsp_valid_o), 32'd1);
         check("stall.rdata", bus.rsp_rdata_o, 32'h11223344);
         check("stall.err", 32'(bus.rsp_err_o), 32'd0);
         check("stall.req_ready", 32'(bus.req_ready_o), 32'd0);
         check("stall.busy", 32'(bus.busy_o), 32'd1);
      end
      end_rsp();
      check("stall.done_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("stall.done_busy", 32'(bus.busy_o), 32'd0);
      check("stall.done_ready", 32'(bus.req_ready_o), 32'd1);

      // Top-of-memory range checks; neighbours must survive a faulting store.
      txn("sw3fc", 1'b1, MASK_W, 32'h3FC, 32'h01020304, 32'h0, 1'b0, 2);
      txn("sw000", 1'b1, MASK_W, 32'h000, 32'h0A0B0C0D, 32'h0, 1'b0, 2);
      txn("lw3fe", 1'b0, MASK_W, 32'h3FE, 32'h0, 32'h0, 1'b1, 2);
      txn("sw3fe", 1'b1, MASK_W, 32'h3FE, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
      txn("lw3fc", 1'b0, MASK_W, 32'h3FC, 32'h0, 32'h01020304, 1'b0, 2);
      txn("lw000", 1'b0, MASK_W, 32'h000, 32'h0, 32'h0A0B0C0D, 1'b0, 2);
      txn("lb3ff", 1'b0, MASK_LB, 32'h3FF, 32'h0, 32'h00000004, 1'b0, 2);
      txn("lw400", 1'b0, MASK_W, 32'h400, 32'h0, 32'h0, 1'b1, 2);

`ifdef DATA_MEM_MISALIGN_EN
      // Split store interrupted by reset in its second beat.
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_mask_i  = MASK_W;
      bus.req_addr_i  = 32'h0E;
      bus.req_wdata_i = 32'hDEADBEEF;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("rstb1.busy_beat0", 32'(bus.busy_o), 32'd1);
      @(negedge clk);
      check("rstb1.busy_beat1", 32'(bus.busy_o), 32'd1);
      check("rstb1.valid_beat1", 32'(bus.rsp_valid_o), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rstb1.valid", 32'(bus.rsp_valid_o), 32'd0);
      check("rstb1.busy", 32'(bus.busy_o), 32'd0);
      check("rstb1.req_ready", 32'(bus.req_ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      check("rstb1.no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      txn("rstb1.lw0c", 1'b0, MASK_W, 32'h0C, 32'h0, 32'hAABBDEAD, 1'b0, 2);
      txn("rstb1.lw10", 1'b0, MASK_W, 32'h10, 32'h0, 32'h11223344, 1'b0, 2);
`else
      txn("sw0e", 1'b1, MASK_W, 32'h0E, 32'hDEADBEEF, 32'h0, 1'b1, 2);
      txn("sw0e.lw0c", 1'b0, MASK_W, 32'h0C, 32'h0, 32'hAABBCCDD, 1'b0, 2);
      txn("sw0e.lw10", 1'b0, MASK_W, 32'h10, 32'h0, 32'h11223344, 1'b0, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
